// File: rtl/union_find_cc.sv
// union_find_cc: frame-scoped union/find engine for connected-component
// labelling. Path halving on every walk, minimum-index root rule, operand
// range checking, merge reporting and a RESOLVE sweep that streams a compact
// 0-based label for every node.
module union_find_cc #(
    parameter int N          = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] node1,
    input  logic [ADDR_WIDTH-1:0] node2,
    output logic [ADDR_WIDTH-1:0] result,
    output logic                  merged,
    output logic                  err,
    output logic                  done,
    output logic                  idle,
    output logic                  lbl_valid,
    output logic [ADDR_WIDTH-1:0] lbl_node,
    output logic [ADDR_WIDTH-1:0] lbl_value,
    output logic [ADDR_WIDTH:0]   label_count
);

    // Storage index width; node values are always < N so the low bits suffice.
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam int N_LAST_I = N - 1;

    localparam logic [ADDR_WIDTH:0] NODE_LIMIT = N[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] NODE_LAST  = N_LAST_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE_W      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    localparam logic [1:0] OP_IDLE    = 2'b00;
    localparam logic [1:0] OP_UNION   = 2'b01;
    localparam logic [1:0] OP_FIND    = 2'b10;
    localparam logic [1:0] OP_RESOLVE = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_FIND1   = 3'd2,
        ST_FIND2   = 3'd3,
        ST_LINK    = 3'd4,
        ST_RESOLVE = 3'd5
    } state_t;

    // Smaller of two node indices; the surviving root is always the minimum.
    function automatic logic [ADDR_WIDTH-1:0] min_node(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [ADDR_WIDTH-1:0] b
    );
        if (a < b) begin
            min_node = a;
        end else begin
            min_node = b;
        end
    endfunction

    // Larger of two node indices; this root gets re-parented on a merge.
    function automatic logic [ADDR_WIDTH-1:0] max_node(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [ADDR_WIDTH-1:0] b
    );
        if (a < b) begin
            max_node = b;
        end else begin
            max_node = a;
        end
    endfunction

    // Storage address from a node index.
    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
        to_idx = a[IDX_W-1:0];
    endfunction

    // Operand outside the node range.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        out_of_range = ({1'b0, a} >= NODE_LIMIT);
    endfunction

    // Set forest (parent[i] <= i always holds) and resolved labels.
    logic [ADDR_WIDTH-1:0] parent_mem [N];
    logic [ADDR_WIDTH-1:0] label_mem  [N];

    state_t                state_r;
    logic [ADDR_WIDTH:0]   sweep_r;
    logic [ADDR_WIDTH:0]   cnt_r;
    logic [ADDR_WIDTH-1:0] x_r;
    logic [ADDR_WIDTH-1:0] r1_r;
    logic [ADDR_WIDTH-1:0] node2_r;
    logic [1:0]            op_r;
    logic                  err_pend_r;

    logic [ADDR_WIDTH-1:0] result_r;
    logic                  merged_r;
    logic                  err_r;
    logic                  done_r;
    logic                  idle_r;
    logic                  lbl_valid_r;
    logic [ADDR_WIDTH-1:0] lbl_node_r;
    logic [ADDR_WIDTH-1:0] lbl_value_r;
    logic [ADDR_WIDTH:0]   label_count_r;

    logic [ADDR_WIDTH-1:0] sweep_idx_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic [ADDR_WIDTH-1:0] p_s;
    logic [ADDR_WIDTH-1:0] g_s;
    logic [ADDR_WIDTH-1:0] lbl_rd_s;
    logic                  walk_root_s;
    logic                  res_root_s;
    logic [ADDR_WIDTH-1:0] res_label_s;
    logic                  op_bad_s;

    logic                  par_we_s;
    logic [ADDR_WIDTH-1:0] par_waddr_s;
    logic [ADDR_WIDTH-1:0] par_wdata_s;
    logic                  lbl_we_s;
    logic [ADDR_WIDTH-1:0] lbl_waddr_s;
    logic [ADDR_WIDTH-1:0] lbl_wdata_s;

    assign sweep_idx_s = sweep_r[ADDR_WIDTH-1:0];

    // First parent read port follows the sweep during RESOLVE, the walker otherwise.
    always_comb begin
        rd_addr_s = x_r;
        if (state_r == ST_RESOLVE) begin
            rd_addr_s = sweep_idx_s;
        end else begin
            rd_addr_s = x_r;
        end
    end

    // p = parent[x], g = parent[p]; label of the parent is already final in a sweep.
    assign p_s         = parent_mem[to_idx(rd_addr_s)];
    assign g_s         = parent_mem[to_idx(p_s)];
    assign lbl_rd_s    = label_mem[to_idx(p_s)];
    assign walk_root_s = (p_s == x_r);
    assign res_root_s  = (p_s == sweep_idx_s);
    assign res_label_s = res_root_s ? cnt_r[ADDR_WIDTH-1:0] : lbl_rd_s;

    // Range check on the operands the requested op actually uses.
    always_comb begin
        op_bad_s = 1'b0;
        case (op)
            OP_FIND:  op_bad_s = out_of_range(node1);
            OP_UNION: op_bad_s = out_of_range(node1) || out_of_range(node2);
            default:  op_bad_s = 1'b0;
        endcase
    end

    // Parent write port: init fill, path-halving writes and the link write.
    always_comb begin
        par_we_s    = 1'b0;
        par_waddr_s = {ADDR_WIDTH{1'b0}};
        par_wdata_s = {ADDR_WIDTH{1'b0}};
        if (!frame_start) begin
            case (state_r)
                ST_INIT: begin
                    par_we_s    = 1'b1;
                    par_waddr_s = sweep_idx_s;
                    par_wdata_s = sweep_idx_s;
                end
                ST_FIND1, ST_FIND2: begin
                    if (!walk_root_s) begin
                        par_we_s    = 1'b1;
                        par_waddr_s = x_r;
                        par_wdata_s = g_s;
                    end else begin
                        par_we_s    = 1'b0;
                    end
                end
                ST_LINK: begin
                    if (r1_r != x_r) begin
                        par_we_s    = 1'b1;
                        par_waddr_s = max_node(r1_r, x_r);
                        par_wdata_s = min_node(r1_r, x_r);
                    end else begin
                        par_we_s    = 1'b0;
                    end
                end
                default: begin
                    par_we_s = 1'b0;
                end
            endcase
        end else begin
            par_we_s = 1'b0;
        end
    end

    // Label write port: one label per sweep beat.
    always_comb begin
        lbl_we_s    = 1'b0;
        lbl_waddr_s = sweep_idx_s;
        lbl_wdata_s = res_label_s;
        if (!frame_start && (state_r == ST_RESOLVE) && (sweep_r != NODE_LIMIT)) begin
            lbl_we_s = 1'b1;
        end else begin
            lbl_we_s = 1'b0;
        end
    end

    // Parent storage write; contents are rebuilt by INIT after every reset.
    always_ff @(posedge clk) begin
        if (par_we_s) begin
            parent_mem[to_idx(par_waddr_s)] <= par_wdata_s;
        end
    end

    // Label storage write; only meaningful after a RESOLVE sweep.
    always_ff @(posedge clk) begin
        if (lbl_we_s) begin
            label_mem[to_idx(lbl_waddr_s)] <= lbl_wdata_s;
        end
    end

    // Control FSM with all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_INIT;
            sweep_r       <= {(ADDR_WIDTH+1){1'b0}};
            cnt_r         <= {(ADDR_WIDTH+1){1'b0}};
            x_r           <= {ADDR_WIDTH{1'b0}};
            r1_r          <= {ADDR_WIDTH{1'b0}};
            node2_r       <= {ADDR_WIDTH{1'b0}};
            op_r          <= OP_IDLE;
            err_pend_r    <= 1'b0;
            result_r      <= {ADDR_WIDTH{1'b0}};
            merged_r      <= 1'b0;
            err_r         <= 1'b0;
            done_r        <= 1'b0;
            idle_r        <= 1'b0;
            lbl_valid_r   <= 1'b0;
            lbl_node_r    <= {ADDR_WIDTH{1'b0}};
            lbl_value_r   <= {ADDR_WIDTH{1'b0}};
            label_count_r <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            lbl_valid_r <= 1'b0;
            if (frame_start) begin
                // A new frame aborts whatever is running and rebuilds the forest.
                state_r    <= ST_INIT;
                sweep_r    <= {(ADDR_WIDTH+1){1'b0}};
                idle_r     <= 1'b0;
                err_pend_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_INIT: begin
                        if (sweep_r == NODE_LAST) begin
                            state_r <= ST_IDLE;
                            idle_r  <= 1'b1;
                        end else begin
                            sweep_r <= sweep_r + ONE_W;
                        end
                    end
                    ST_IDLE: begin
                        if (err_pend_r) begin
                            err_pend_r <= 1'b0;
                            done_r     <= 1'b1;
                            err_r      <= 1'b1;
                            idle_r     <= 1'b1;
                        end else if (idle_r && (op != OP_IDLE)) begin
                            idle_r <= 1'b0;
                            if (op_bad_s) begin
                                err_pend_r <= 1'b1;
                            end else begin
                                op_r    <= op;
                                x_r     <= node1;
                                node2_r <= node2;
                                case (op)
                                    OP_UNION, OP_FIND: begin
                                        state_r <= ST_FIND1;
                                    end
                                    OP_RESOLVE: begin
                                        state_r <= ST_RESOLVE;
                                        sweep_r <= {(ADDR_WIDTH+1){1'b0}};
                                        cnt_r   <= {(ADDR_WIDTH+1){1'b0}};
                                    end
                                    default: begin
                                        state_r <= ST_IDLE;
                                        idle_r  <= 1'b1;
                                    end
                                endcase
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_FIND1: begin
                        if (walk_root_s) begin
                            if (op_r == OP_UNION) begin
                                r1_r    <= x_r;
                                x_r     <= node2_r;
                                state_r <= ST_FIND2;
                            end else begin
                                result_r <= x_r;
                                merged_r <= 1'b0;
                                done_r   <= 1'b1;
                                idle_r   <= 1'b1;
                                state_r  <= ST_IDLE;
                            end
                        end else begin
                            x_r <= g_s;
                        end
                    end
                    ST_FIND2: begin
                        if (walk_root_s) begin
                            state_r <= ST_LINK;
                        end else begin
                            x_r <= g_s;
                        end
                    end
                    ST_LINK: begin
                        result_r <= min_node(r1_r, x_r);
                        merged_r <= (r1_r != x_r);
                        done_r   <= 1'b1;
                        idle_r   <= 1'b1;
                        state_r  <= ST_IDLE;
                    end
                    ST_RESOLVE: begin
                        if (sweep_r == NODE_LIMIT) begin
                            label_count_r <= cnt_r;
                            done_r        <= 1'b1;
                            idle_r        <= 1'b1;
                            state_r       <= ST_IDLE;
                        end else begin
                            lbl_valid_r <= 1'b1;
                            lbl_node_r  <= sweep_idx_s;
                            lbl_value_r <= res_label_s;
                            if (res_root_s) begin
                                cnt_r <= cnt_r + ONE_W;
                            end
                            sweep_r <= sweep_r + ONE_W;
                        end
                    end
                    default: begin
                        state_r <= ST_INIT;
                        sweep_r <= {(ADDR_WIDTH+1){1'b0}};
                        idle_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign result      = result_r;
    assign merged      = merged_r;
    assign err         = err_r;
    assign done        = done_r;
    assign idle        = idle_r;
    assign lbl_valid   = lbl_valid_r;
    assign lbl_node    = lbl_node_r;
    assign lbl_value   = lbl_value_r;
    assign label_count = label_count_r;

endmodule

// File: tb/tb_union_find_cc.sv
// Testbench for union_find_cc: directed scenarios plus random ops, checked by
// a scoreboard fed from a set-level reference model (each node maps to the
// minimum member of its set).
module tb_union_find_cc;

    localparam int N      = 256;
    localparam int AW     = 9;
    localparam int BUDGET = 2000;

    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_UNION   = 2'b01;
    localparam logic [1:0] OP_FIND    = 2'b10;
    localparam logic [1:0] OP_RESOLVE = 2'b11;

    localparam int K_BEAT = 0;
    localparam int K_OP   = 1;
    localparam int K_ERR  = 2;
    localparam int K_RES  = 3;

    logic          clk         = 1'b0;
    logic          reset_n     = 1'b0;
    logic          frame_start = 1'b0;
    logic [1:0]    op          = 2'b00;
    logic [AW-1:0] node1       = '0;
    logic [AW-1:0] node2       = '0;
    logic [AW-1:0] result;
    logic          merged;
    logic          err;
    logic          done;
    logic          idle;
    logic          lbl_valid;
    logic [AW-1:0] lbl_node;
    logic [AW-1:0] lbl_value;
    logic [AW:0]   label_count;

    union_find_cc #(.N(N), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .op(op),
        .node1(node1), .node2(node2), .result(result), .merged(merged),
        .err(err), .done(done), .idle(idle), .lbl_valid(lbl_valid),
        .lbl_node(lbl_node), .lbl_value(lbl_value), .label_count(label_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int a;
        int b;
        bit is_union;
    } exp_t;

    exp_t exp_q[$];
    int   comp[N];
    int   checks   = 0;
    int   failures = 0;
    int   beats    = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < N; i++) comp[i] = i;
    endtask

    task automatic push_resolve();
        int lab[N];
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (comp[i] == i) begin
                lab[i] = cnt;
                cnt++;
            end else begin
                lab[i] = lab[comp[i]];
            end
            exp_q.push_back('{K_BEAT, i, lab[i], 1'b0});
        end
        exp_q.push_back('{K_RES, cnt, 0, 1'b0});
    endtask

    task automatic push_expect(input logic [1:0] o, input int a, input int b);
        int ra, rb, lo, hi;
        if (o == OP_RESOLVE) begin
            push_resolve();
        end else if (o == OP_NONE) begin
            lo = 0;
        end else if (a >= N || (o == OP_UNION && b >= N)) begin
            exp_q.push_back('{K_ERR, 0, 0, 1'b0});
        end else if (o == OP_FIND) begin
            exp_q.push_back('{K_OP, comp[a], 0, 1'b0});
        end else begin
            ra = comp[a];
            rb = comp[b];
            lo = (ra < rb) ? ra : rb;
            hi = (ra < rb) ? rb : ra;
            exp_q.push_back('{K_OP, lo, (ra != rb) ? 1 : 0, 1'b1});
            for (int i = 0; i < N; i++) if (comp[i] == hi) comp[i] = lo;
        end
    endtask

    // Monitor: pops one expectation per stream beat and per done pulse.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && lbl_valid) begin
                beats++;
                if (exp_q.size() == 0) begin
                    chk("stray_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_kind", K_BEAT, e.kind);
                    chk("lbl_node", int'(lbl_node), e.a);
                    chk("lbl_value", int'(lbl_value), e.b);
                end
            end
            if (reset_n && done) begin
                if (exp_q.size() == 0) begin
                    chk("stray_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    case (e.kind)
                        K_OP: begin
                            chk("result", int'(result), e.a);
                            if (e.is_union) chk("merged", int'(merged), e.b);
                            chk("err_clear", int'(err), 0);
                        end
                        K_ERR: chk("err_set", int'(err), 1);
                        K_RES: begin
                            chk("label_count", int'(label_count), e.a);
                            chk("err_clear_res", int'(err), 0);
                        end
                        default: chk("done_kind", K_OP, e.kind);
                    endcase
                end
            end
        end
    end

    // Issue one op (caller at negedge); lat = edges from accept to done.
    task automatic issue(input logic [1:0] o, input int a, input int b,
                         input bit poke, output int lat);
        int guard;
        guard = 0;
        while (!idle && guard < BUDGET) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_before_op", int'(idle), 1);
        push_expect(o, a, b);
        op    = o;
        node1 = AW'(a);
        node2 = AW'(b);
        @(posedge clk);
        #1;
        op  = OP_NONE;
        lat = 0;
        while (lat < BUDGET) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 1) begin
                op    = OP_FIND;
                node1 = AW'(3);
            end else begin
                op = OP_NONE;
            end
            if (done) break;
        end
        chk("done_seen", int'(done), 1);
        @(negedge clk);
    endtask

    // Count edges until idle after INIT entry; no done may appear meanwhile.
    task automatic wait_init(input string name);
        int cyc;
        int seen_done;
        cyc       = 0;
        seen_done = 0;
        while (cyc < BUDGET) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen_done++;
            if (idle) break;
        end
        chk(name, cyc, N);
        chk({name, "_no_done"}, seen_done, 0);
        @(negedge clk);
    endtask

    task automatic pulse_frame(input string name);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        op          = OP_NONE;
        chk({name, "_idle_low"}, int'(idle), 0);
        model_init();
        wait_init(name);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int lat, lat1, lat2, r, a, b;
        logic [1:0] o;
        model_init();
        repeat (3) @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_merged", int'(merged), 0);
        chk("rst_lbl_valid", int'(lbl_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_lbl_node", int'(lbl_node), 0);
        chk("rst_lbl_value", int'(lbl_value), 0);
        chk("rst_label_count", int'(label_count), 0);
        chk("rst_idle", int'(idle), 0);
        reset_n = 1'b1;
        wait_init("reset_init_cycles");
        pulse_frame("frame_init_cycles");

        issue(OP_FIND, 7, 0, 1'b0, lat);
        chk("find7_latency", lat, 1);
        issue(OP_UNION, 1, 2, 1'b0, lat);
        chk("union_fresh_latency", lat, 3);
        issue(OP_UNION, 3, 4, 1'b0, lat);
        issue(OP_FIND, 2, 0, 1'b0, lat);
        issue(OP_FIND, 4, 0, 1'b0, lat);
        issue(OP_UNION, 2, 4, 1'b0, lat);
        issue(OP_FIND, 4, 0, 1'b0, lat);
        issue(OP_UNION, 4, 1, 1'b0, lat);

        pulse_frame("frame_chain");
        for (int k = 0; k < 10; k++) issue(OP_UNION, k, k + 1, 1'b0, lat);
        issue(OP_FIND, 10, 0, 1'b0, lat1);
        issue(OP_FIND, 10, 0, 1'b0, lat2);
        chk("find10_repeat_not_slower", (lat2 <= lat1) ? 1 : 0, 1);
        issue(OP_UNION, 28, 29, 1'b0, lat);
        issue(OP_UNION, 26, 28, 1'b0, lat);
        issue(OP_UNION, 24, 26, 1'b0, lat);
        issue(OP_UNION, 22, 24, 1'b0, lat);
        issue(OP_UNION, 20, 22, 1'b0, lat);
        issue(OP_FIND, 29, 0, 1'b0, lat);
        chk("find29_depth5_latency", lat, 4);
        issue(OP_FIND, 29, 0, 1'b0, lat);
        chk("find29_halved_latency", lat, 3);

        pulse_frame("frame_resolve");
        issue(OP_UNION, 0, 5, 1'b0, lat);
        issue(OP_UNION, 3, 9, 1'b0, lat);
        issue(OP_UNION, 9, 12, 1'b0, lat);
        beats = 0;
        issue(OP_RESOLVE, 0, 0, 1'b1, lat);
        chk("resolve_latency", lat, N + 1);
        chk("resolve_beats", beats, N);

        issue(OP_FIND, 300, 0, 1'b0, lat);
        chk("find_oor_latency", lat, 1);
        issue(OP_UNION, 5, 400, 1'b0, lat);
        chk("union_oor_latency", lat, 1);
        issue(OP_FIND, 5, 0, 1'b0, lat);
        issue(OP_FIND, 12, 0, 1'b0, lat);

        op    = OP_UNION;
        node1 = AW'(2);
        node2 = AW'(3);
        @(posedge clk);
        #1;
        op = OP_NONE;
        @(posedge clk);
        #1;
        chk("abort_union_busy", int'(idle), 0);
        @(negedge clk);
        pulse_frame("abort_union_init");
        issue(OP_FIND, 2, 0, 1'b0, lat);

        op    = OP_UNION;
        node1 = AW'(4);
        node2 = AW'(6);
        pulse_frame("fs_with_op_init");
        issue(OP_FIND, 6, 0, 1'b0, lat);

        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 99);
            a = $urandom_range(0, 39);
            b = $urandom_range(0, 39);
            if ($urandom_range(0, 19) == 0) a = $urandom_range(N, (1 << AW) - 1);
            if (r < 45)      o = OP_UNION;
            else if (r < 93) o = OP_FIND;
            else             o = OP_RESOLVE;
            issue(o, a, b, 1'b0, lat);
        end

        chk("queue_empty_before_reset_test", exp_q.size(), 0);
        push_expect(OP_RESOLVE, 0, 0);
        op = OP_RESOLVE;
        @(posedge clk);
        #1;
        op = OP_NONE;
        repeat (5) @(posedge clk);
        #1;
        chk("stream_active", int'(lbl_valid), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_lbl_valid", int'(lbl_valid), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_idle", int'(idle), 0);
        chk("reset_lbl_node", int'(lbl_node), 0);
        chk("reset_label_count", int'(label_count), 0);
        exp_q.delete();
        model_init();
        @(negedge clk);
        reset_n = 1'b1;
        wait_init("reset_mid_resolve_init");
        issue(OP_FIND, 9, 0, 1'b0, lat);
        chk("queue_empty_at_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
